// File: rtl/seq_detect_sched.sv
// Round-robin scheduler sharing one a->b->(a&b) sequence-detector engine among N requesters.
// Each grant clears the engine, streams the lane's a/b bits for len cycles and reports the match count.
module seq_detect_sched #(
  parameter int N    = 4,
  parameter int LENW = 8,
  parameter int CNTW = 8,
  localparam int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    a_in,
  input  logic [N-1:0]    b_in,
  input  logic [LENW-1:0] len,
  output logic [N-1:0]    gnt,
  output logic            busy,
  output logic            done,
  output logic [IDW-1:0]  done_id,
  output logic [CNTW-1:0] match_cnt,
  output logic            y,
  output logic [1:0]      det_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10,
    ILL  = 2'b11
  } ctrl_e;

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;

  ctrl_e           state_q;
  logic [1:0]      det_q;
  logic [1:0]      det_d;
  logic [N-1:0]    gnt_q;
  logic            done_q;
  logic [IDW-1:0]  id_q;
  logic [IDW-1:0]  last_q;
  logic [CNTW-1:0] match_q;
  logic [LENW-1:0] rem_q;

  logic            a_g;
  logic            b_g;
  logic            y_raw;
  logic            pick_found;
  logic [IDW-1:0]  pick_id;
  logic [IDW-1:0]  cand;

  // The engine always looks at the lane recorded at grant time.
  assign a_g = a_in[id_q];
  assign b_g = b_in[id_q];

  always_comb begin
    det_d = S0;
    y_raw = 1'b0;
    case (det_q)
      S0:      det_d = a_g ? S1 : S0;
      S1:      det_d = b_g ? S2 : S0;
      S2: begin
        det_d = (a_g & b_g) ? S2 : S0;
        y_raw = a_g & b_g;
      end
      default: det_d = S0;
    endcase
  end

  // First requester after the last grant, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDW'((int'(last_q) + k) % N);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_id    = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      det_q   <= S0;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      id_q    <= '0;
      last_q  <= IDW'(N - 1);
      match_q <= '0;
      rem_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gnt_q   <= N'(1) << pick_id;
            id_q    <= pick_id;
            last_q  <= pick_id;
            match_q <= '0;
            det_q   <= S0;
            rem_q   <= len;
            if (len == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          // Dropping the granted request aborts: no done pulse, partial count kept.
          if (!req[id_q]) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            det_q   <= S0;
          end else begin
            det_q <= det_d;
            if (y_raw && (match_q != {CNTW{1'b1}})) begin
              match_q <= match_q + CNTW'(1);
            end
            rem_q <= rem_q - LENW'(1);
            if (rem_q == LENW'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          det_q   <= S0;
        end
        default: begin
          state_q <= IDLE;
          gnt_q   <= '0;
          det_q   <= S0;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign done      = done_q;
  assign done_id   = id_q;
  assign match_cnt = match_q;
  assign det_state = det_q;
  assign y         = y_raw & (state_q == RUN);

endmodule

// File: tb/tb_seq_detect_sched.sv
// Directed bench for seq_detect_sched: default instance plus a CNTW=3 instance for saturation.
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req, a_in, b_in;
  logic [7:0] len;
  logic [3:0] gnt;
  logic       busy, done, y;
  logic [1:0] done_id, det_state;
  logic [7:0] match_cnt;

  logic [3:0] req_s, a_s, b_s;
  logic [7:0] len_s;
  logic [3:0] gnt_s;
  logic       busy_s, done_s, y_s;
  logic [1:0] done_id_s, det_s;
  logic [2:0] match_s;

  int errors = 0;
  int checks = 0;
  int lane   = 0;

  always #5 clk = ~clk;

  seq_detect_sched #(.N(4), .LENW(8), .CNTW(8)) u_dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in), .len(len),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .match_cnt(match_cnt),
    .y(y), .det_state(det_state)
  );

  seq_detect_sched #(.N(4), .LENW(8), .CNTW(3)) u_sat (
    .clk(clk), .reset(reset), .req(req_s), .a_in(a_s), .b_in(b_s), .len(len_s),
    .gnt(gnt_s), .busy(busy_s), .done(done_s), .done_id(done_id_s), .match_cnt(match_s),
    .y(y_s), .det_state(det_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ab(input logic a, input logic b);
    a_in = 4'(a) << lane;
    b_in = 4'(b) << lane;
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},  32'(gnt),       32'(4'b0000));
    chk({tag, "_busy"}, 32'(busy),      32'(1'b0));
    chk({tag, "_done"}, 32'(done),      32'(1'b0));
    chk({tag, "_y"},    32'(y),         32'(1'b0));
    chk({tag, "_det"},  32'(det_state), 32'(2'b00));
  endtask

  logic       t1_a [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic       t1_b [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] t1_det [5] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
  logic       t1_y [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [1:0] rr_id [4] = '{2'd0, 2'd1, 2'd3, 2'd0};

  initial begin
    reset = 1'b1; req = 4'b0000; a_in = 4'b0000; b_in = 4'b0000; len = 8'd0;
    req_s = 4'b0000; a_s = 4'b0000; b_s = 4'b0000; len_s = 8'd0;
    #12;
    chk_idle("rst");
    chk("rst_done_id", 32'(done_id), 32'(2'd0));
    chk("rst_match", 32'(match_cnt), 32'(8'd0));
    reset = 1'b0;

    // Single lane, 5-cycle sequence; len and other-lane requests change mid-run.
    lane = 0; req = 4'b0001; len = 8'd5;
    tick();
    len = 8'd200;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) req = 4'b1111;
      drive_ab(t1_a[i], t1_b[i]);
      chk("t1_det", 32'(det_state), 32'(t1_det[i]));
      chk("t1_y", 32'(y), 32'(t1_y[i]));
      chk("t1_gnt", 32'(gnt), 32'(4'b0001));
      chk("t1_busy", 32'(busy), 32'(1'b1));
      chk("t1_done_run", 32'(done), 32'(1'b0));
      tick();
    end
    req = 4'b0000; drive_ab(1'b0, 1'b0);
    chk("t1_done", 32'(done), 32'(1'b1));
    chk("t1_det_done", 32'(det_state), 32'(2'b00));
    chk("t1_done_id", 32'(done_id), 32'(2'd0));
    chk("t1_match", 32'(match_cnt), 32'(8'd2));
    chk("t1_y_done", 32'(y), 32'(1'b0));
    tick();
    chk_idle("t1_post");

    // Round robin with req=1011, len=1, starting from a fresh pointer.
    reset = 1'b1; #1; reset = 1'b0;
    req = 4'b1011; len = 8'd1;
    for (int r = 0; r < 4; r++) begin
      tick();
      chk("rr_gnt_run", 32'(gnt), 32'(4'b0001 << rr_id[r]));
      chk("rr_done_run", 32'(done), 32'(1'b0));
      tick();
      chk("rr_done", 32'(done), 32'(1'b1));
      chk("rr_id", 32'(done_id), 32'(rr_id[r]));
      chk("rr_gnt_done", 32'(gnt), 32'(4'b0001 << rr_id[r]));
      if (r == 3) req = 4'b0000;
      tick();
      chk("rr_idle_gnt", 32'(gnt), 32'(4'b0000));
    end

    // Zero length on lane 2.
    req = 4'b0100; len = 8'd0;
    tick();
    chk("z_gnt", 32'(gnt), 32'(4'b0100));
    chk("z_done", 32'(done), 32'(1'b1));
    chk("z_match", 32'(match_cnt), 32'(8'd0));
    chk("z_y", 32'(y), 32'(1'b0));
    chk("z_id", 32'(done_id), 32'(2'd2));
    req = 4'b0000;
    tick();
    chk_idle("z_post");

    // Abort on the 3rd RUN cycle of lane 3.
    lane = 3; req = 4'b1000; len = 8'd6;
    tick();
    drive_ab(1'b1, 1'b0); tick();
    drive_ab(1'b0, 1'b1); tick();
    drive_ab(1'b0, 1'b0); req = 4'b0000;
    chk("ab3_det", 32'(det_state), 32'(2'b10));
    tick();
    chk_idle("ab3");
    chk("ab3_match", 32'(match_cnt), 32'(8'd0));
    chk("ab3_id", 32'(done_id), 32'(2'd3));

    // Abort on the 5th RUN cycle of lane 1 keeps the partial count.
    lane = 1; req = 4'b0010; len = 8'd6;
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_ab(t1_a[i], t1_b[i]);
      tick();
    end
    drive_ab(1'b0, 1'b0); req = 4'b0000;
    tick();
    chk_idle("ab5");
    chk("ab5_match", 32'(match_cnt), 32'(8'd2));
    chk("ab5_id", 32'(done_id), 32'(2'd1));
    tick();
    chk("ab5_nodone", 32'(done), 32'(1'b0));

    // Reset mid-run with the engine in S2.
    lane = 0; req = 4'b0001; len = 8'd6;
    tick();
    drive_ab(1'b1, 1'b0); tick();
    drive_ab(1'b0, 1'b1); tick();
    drive_ab(1'b1, 1'b1);
    chk("mr_det_pre", 32'(det_state), 32'(2'b10));
    chk("mr_y_pre", 32'(y), 32'(1'b1));
    reset = 1'b1; #1;
    chk_idle("mr");
    chk("mr_id", 32'(done_id), 32'(2'd0));
    chk("mr_match", 32'(match_cnt), 32'(8'd0));
    req = 4'b0010; drive_ab(1'b0, 1'b0);
    reset = 1'b0;
    tick();
    chk("mr_gnt", 32'(gnt), 32'(4'b0010));
    chk("mr_gid", 32'(done_id), 32'(2'd1));
    req = 4'b0000;
    tick();
    chk("mr_abort_gnt", 32'(gnt), 32'(4'b0000));

    // Saturation on the CNTW=3 instance: 8 detections clamp at 7.
    req_s = 4'b0001; len_s = 8'd10; a_s = 4'b1111; b_s = 4'b1111;
    tick();
    for (int c = 1; c <= 10; c++) begin
      if (c == 9)  chk("sat_c9", 32'(match_s), 32'(3'd6));
      if (c == 10) chk("sat_c10", 32'(match_s), 32'(3'd7));
      chk("sat_run_done", 32'(done_s), 32'(1'b0));
      tick();
    end
    req_s = 4'b0000;
    chk("sat_done", 32'(done_s), 32'(1'b1));
    chk("sat_match", 32'(match_s), 32'(3'd7));
    tick();
    chk("sat_post_gnt", 32'(gnt_s), 32'(4'b0000));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_detect_sched.md
Name: seq_detect_sched

Overview:
Round-robin scheduler that shares one embedded a→b→(a&b) sequence-detector engine among N requesters. It grants the engine to one requester at a time and clears the detector to S0. It then streams that requester's a/b bits through the engine for a programmed number of cycles, counts detections, and reports the result with a done handshake. It sits between the per-lane stimulus sources and the shared detector in the FSM test datapath.

Parameters:
N, 4, number of requesters (2..8); IDW = $clog2(N) is a localparam
LENW, 8, width of run-length input
CNTW, 8, width of match counter

Ports:
clk  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
req  in  N  per-requester request; must be held until done
a_in  in  N  per-requester a bit
b_in  in  N  per-requester b bit
len  in  LENW  run length in cycles, sampled at grant
gnt  out  N  one-hot grant; zero when idle
busy  out  1  high in RUN or DONE
done  out  1  one-cycle pulse at end of run
done_id  out  IDW  index of the current/last granted requester
match_cnt  out  CNTW  detections counted in the current/last run
y  out  1  live detector output (Mealy), gated to 0 outside RUN
det_state  out  2  engine state: S0=00, S1=01, S2=10

Behaviour:
- Reset (async, high): ctrl=IDLE, det_state=S0, gnt=0, busy=0, done=0, done_id=0, match_cnt=0, y=0, rr pointer last=N-1.
- Ctrl FSM has four states: IDLE, RUN, DONE, and an illegal encoding that returns to IDLE.
- IDLE: when req!=0, pick the first set bit searching from last+1 with wraparound. On the next edge:
  - gnt=onehot(g), done_id=g, last=g, match_cnt=0, det_state=S0, rem=len.
  - Go to RUN, or to DONE if len==0.
- RUN, each cycle, engine sees a=a_in[g], b=b_in[g]:
  - S0: next = a ? S1 : S0; y=0.
  - S1: next = b ? S2 : S0; y=0.
  - S2: next = (a&b) ? S2 : S0; y = a&b.
  - At each edge: det_state <= next; if y, match_cnt++, saturating at 2^CNTW-1; rem--. If rem==1, go to DONE.
  - Exactly len RUN cycles per grant.
- DONE: lasts one cycle with gnt still asserted and done=1. done_id and match_cnt are final. Next edge goes to IDLE with gnt=0, det_state=S0.
- IDLE lasts at least 1 cycle between runs; no back-to-back grants.
- Abort: if req[g]=0 during RUN, next edge goes to IDLE. gnt clears, det_state=S0, no done pulse, and match_cnt holds its partial value. last stays g.
- req changes on non-granted lanes during RUN or DONE have no effect. len changes after grant are ignored.
- Reset asserted mid-run returns immediately to the reset values; no done pulse.
- Invariants:
  - gnt is one-hot or zero.
  - busy == (gnt != 0).
  - done implies busy.
  - y=0 whenever ctrl != RUN.

Test Plan:
- Single lane, 5-cycle sequence. Setup: N=4, req=0001, len=5. a/b per RUN cycle = (1,0),(0,1),(1,1),(1,1),(0,0). Required: det_state 00→01→10→10→10→00; y=0,0,1,1,0; done pulses on cycle 6 after grant; done_id=0; match_cnt=2.
- Round-robin order: req=1011 held, len=1. Required: grant order is 0, 1, 3, 0; each run is IDLE→RUN→DONE, 3 cycles per run.
- Saturation: CNTW=3, len=10, a=b=1 every cycle. Required: 8 detections counted; match_cnt saturates at 7.
- Zero length: len=0, req=0100. Required: gnt=0100 for exactly one cycle, done=1 in that cycle, match_cnt=0, y stays 0.
- Abort: len=6, drop req[g] on the 3rd RUN cycle. Required: gnt=0 on the next cycle, no done pulse, det_state=00, match_cnt holds its partial value.
- Reset mid-run: assert reset during RUN with det_state=10. Required: all outputs go to reset values immediately, without waiting for a clock edge. After release with req=0010, the first grant goes to lane 1 because last is reset to N-1.
